// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the System ID checker.
// Holds the FSM state enum, SysID word offsets and default expected values.
package sysid_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        FIN
    } state_t;

    localparam int SYSID_WORD_ID = 0;
    localparam int SYSID_WORD_TS = 1;

    localparam logic [31:0] SYSID_DEF_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEF_TS = 32'd1616605598;

endpackage

// File: rtl/sysid_check_timer.sv
// Clearable saturating stall counter; expired is high once the count
// reaches LIMIT-1. Ports: clock, reset, clear, enable -> expired.
module sysid_check_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that reads SysID word 0 (ID) and word 1
// (timestamp), compares both to expected values and reports pass/fail.
// Ports: clock, reset, start in; avm_address/avm_read out, avm_readdata/
// avm_waitrequest in; busy, done, pass, id_match, ts_match, timeout,
// id_value, ts_value out.
// Optional macro SYSID_CHECK_TIMEOUT_EN aborts a read stalled for
// TIMEOUT_CYC cycles; without it reads wait forever and timeout stays 0.
module sysid_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = SYSID_DEF_ID,
    parameter logic [31:0] EXPECTED_TS = SYSID_DEF_TS,
    parameter int          ADDR_W      = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_match,
    output logic              ts_match,
    output logic              timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    state_t state;
    state_t next;

    logic id_acc;
    logic ts_acc;
    logic to_hit;

    // Read strobe and address are pure decodes of the state register, so
    // an asserted reset drops avm_read without waiting for a clock edge.
    always_comb begin
        avm_read    = 1'b0;
        avm_address = '0;
        case (state)
            RD_ID: begin
                avm_read    = 1'b1;
                avm_address = ADDR_W'(SYSID_WORD_ID);
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = ADDR_W'(SYSID_WORD_TS);
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = (state == FIN);
    assign id_acc = (state == RD_ID) && !avm_waitrequest;
    assign ts_acc = (state == RD_TS) && !avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic stalled;
    logic expired;

    // Counter only advances while a read is stalled; any accepted
    // transfer or a non-read state returns it to zero.
    assign stalled = avm_read && avm_waitrequest;

    sysid_check_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!stalled),
        .enable  (stalled),
        .expired (expired)
    );

    assign to_hit = stalled && expired;
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (start) next = RD_ID;
            end
            RD_ID: begin
                if (!avm_waitrequest) next = RD_TS;
                else if (to_hit)      next = FIN;
            end
            RD_TS: begin
                if (!avm_waitrequest || to_hit) next = FIN;
            end
            FIN: begin
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pass     <= 1'b0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            state <= next;
            if ((state == IDLE) && start) begin
                pass     <= 1'b0;
                id_match <= 1'b0;
                ts_match <= 1'b0;
                timeout  <= 1'b0;
            end
            if (id_acc) begin
                id_value <= avm_readdata;
                id_match <= (avm_readdata == EXPECTED_ID);
            end
            if (ts_acc) begin
                ts_value <= avm_readdata;
                ts_match <= (avm_readdata == EXPECTED_TS);
            end
            if (to_hit) begin
                timeout <= 1'b1;
            end
            if (state == FIN) begin
                pass <= id_match && ts_match && !timeout;
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker with a behavioural SysID slave.
// Covers reset, nominal, stalls, mismatch, random runs, start while busy,
// timeout behaviour and reset in the middle of a read.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1616605598;
    localparam int          TO     = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, id_match, ts_match, timeout;
    logic [31:0] id_value, ts_value;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem [2];
    int          stall_id    = 0;
    int          stall_ts    = 0;
    logic        force_stall = 1'b0;
    int          scnt;

    int   xfers      = 0;
    int   stab_err   = 0;
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;
    logic addr_log [$];

    always #5 clock = ~clock;

    sysid_checker #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .ADDR_W      (1),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_match        (id_match),
        .ts_match        (ts_match),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    // Slave: each read stalls for a per-word number of cycles.
    assign avm_readdata    = mem[avm_address];
    assign avm_waitrequest = force_stall ||
        (avm_read && (scnt < (avm_address ? stall_ts : stall_id)));

    always @(posedge clock or posedge reset) begin
        if (reset) scnt <= 0;
        else if (avm_read && avm_waitrequest) scnt <= scnt + 1;
        else scnt <= 0;
    end

    // Bus monitor: counts accepted transfers and checks that a stalled
    // request keeps read and address stable into the next cycle.
    always @(posedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!avm_read || avm_address !== prev_addr))
                stab_err++;
            if (avm_read && !avm_waitrequest) begin
                xfers++;
                addr_log.push_back(avm_address);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
        end
    end

    task automatic clear_mon();
        xfers    = 0;
        stab_err = 0;
        addr_log.delete();
    endtask

    // Pulses start and returns the number of edges (counting the one that
    // samples start) until done is seen; -1 if it never arrives. Returns
    // one edge after done, when pass has been updated.
    task automatic do_check(output int lat);
        lat   = -1;
        start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock); #1;
            if (i == 1) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        if (lat >= 0) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if ({avm_read, avm_address, busy, done, pass, id_match, ts_match,
             timeout} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl: got %b expected 00000000",
                {avm_read, avm_address, busy, done, pass, id_match,
                 ts_match, timeout});
        end
        tests_run++;
        if ({id_value, ts_value} !== 64'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected 0",
                {id_value, ts_value});
        end
        reset = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if ({busy, avm_read} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_idle: got %b expected 00", {busy, avm_read});
        end
    endtask

    task automatic test_nominal();
        int lat;
        logic ok;
        mem[0] = EXP_ID; mem[1] = EXP_TS;
        stall_id = 0; stall_ts = 0;
        clear_mon();
        do_check(lat);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL nom_latency: got %0d expected 3", lat);
        end
        tests_run++;
        if ({pass, id_match, ts_match, timeout} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL nom_flags: got %b expected 1110",
                {pass, id_match, ts_match, timeout});
        end
        ok = (addr_log.size() == 2) && (xfers == 2);
        if (ok) ok = (addr_log[0] == 1'b0) && (addr_log[1] == 1'b1);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL nom_xfers: got %0d transfers expected 2 (addr 0,1)",
                xfers);
        end
        tests_run++;
        if ({id_value, ts_value} !== {EXP_ID, EXP_TS}) begin
            tests_failed++;
            $display("FAIL nom_values: got %h expected %h",
                {id_value, ts_value}, {EXP_ID, EXP_TS});
        end
        tests_run++;
        if ({done, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL nom_done_once: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_stalls();
        int lat;
        mem[0] = EXP_ID; mem[1] = EXP_TS;
        stall_id = 3; stall_ts = 3;
        clear_mon();
        do_check(lat);
        tests_run++;
        if (lat !== 9) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d expected 9", lat);
        end
        tests_run++;
        if (stab_err !== 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d violations expected 0",
                stab_err);
        end
        tests_run++;
        if (xfers !== 2) begin
            tests_failed++;
            $display("FAIL stall_xfers: got %0d expected 2", xfers);
        end
        tests_run++;
        if (pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_pass: got %b expected 1", pass);
        end
        stall_id = 0; stall_ts = 0;
    endtask

    task automatic test_mismatch();
        int lat;
        mem[0] = EXP_ID; mem[1] = 32'h1234_5678;
        do_check(lat);
        tests_run++;
        if (ts_value !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL mis_ts_value: got %h expected 12345678", ts_value);
        end
        tests_run++;
        if ({pass, id_match, ts_match} !== 3'b010) begin
            tests_failed++;
            $display("FAIL mis_flags: got %b expected 010",
                {pass, id_match, ts_match});
        end
        mem[1] = EXP_TS;
        do_check(lat);
        tests_run++;
        if ({pass, id_match, ts_match} !== 3'b111) begin
            tests_failed++;
            $display("FAIL mis_recover: got %b expected 111",
                {pass, id_match, ts_match});
        end
    endtask

    task automatic test_random();
        int lat, e_lat;
        logic e_id, e_ts, e_pass;
        for (int n = 0; n < 10; n++) begin
            mem[0]   = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            mem[1]   = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            stall_id = $urandom_range(0, 4);
            stall_ts = $urandom_range(0, 4);
            e_lat  = 3 + stall_id + stall_ts;
            e_id   = (mem[0] == EXP_ID);
            e_ts   = (mem[1] == EXP_TS);
            e_pass = e_id && e_ts;
            do_check(lat);
            tests_run++;
            if (lat !== e_lat) begin
                tests_failed++;
                $display("FAIL rnd%0d_latency: got %0d expected %0d",
                    n, lat, e_lat);
            end
            tests_run++;
            if ({pass, id_match, ts_match} !== {e_pass, e_id, e_ts}) begin
                tests_failed++;
                $display("FAIL rnd%0d_flags: got %b expected %b", n,
                    {pass, id_match, ts_match}, {e_pass, e_id, e_ts});
            end
            tests_run++;
            if ({id_value, ts_value} !== {mem[0], mem[1]}) begin
                tests_failed++;
                $display("FAIL rnd%0d_values: got %h expected %h", n,
                    {id_value, ts_value}, {mem[0], mem[1]});
            end
        end
        stall_id = 0; stall_ts = 0;
    endtask

    task automatic test_start_busy();
        int   ndone = 0;
        int   rdcyc = 0;
        logic sent  = 1'b0;
        mem[0] = EXP_ID; mem[1] = EXP_TS;
        stall_id = 0; stall_ts = 2;
        clear_mon();
        start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (!sent && avm_read && avm_address == 1'b1) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            if (done) ndone++;
        end
        start = 1'b0;
        tests_run++;
        if ({ndone, xfers} !== {32'd1, 32'd2}) begin
            tests_failed++;
            $display("FAIL busy_start: got done=%0d xfers=%0d expected 1/2",
                ndone, xfers);
        end
        stall_ts = 0;
        clear_mon();
        sent  = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (avm_read) rdcyc++;
            if (done && !sent) begin
                start = 1'b1;
                sent  = 1'b1;
            end
        end
        start = 1'b0;
        tests_run++;
        if ({rdcyc, xfers, 31'd0, busy} !== {32'd2, 32'd2, 32'd0}) begin
            tests_failed++;
            $display("FAIL done_start: got rd=%0d xfers=%0d busy=%b expected 2/2/0",
                rdcyc, xfers, busy);
        end
    endtask

    task automatic test_timeout();
        int lat;
        int rdcyc = 0;
        int ndone = 0;
        mem[0] = EXP_ID; mem[1] = EXP_TS;
        stall_id = 0; stall_ts = 0;
        clear_mon();
        force_stall = 1'b1;
        start = 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (avm_read) rdcyc++;
            if (done) ndone++;
        end
        force_stall = 1'b0;
        tests_run++;
        if ({rdcyc, ndone} !== {TO, 32'd1}) begin
            tests_failed++;
            $display("FAIL to_abort: got rd=%0d done=%0d expected %0d/1",
                rdcyc, ndone, TO);
        end
        tests_run++;
        if ({timeout, pass, id_match, ts_match} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL to_flags: got %b expected 1000",
                {timeout, pass, id_match, ts_match});
        end
        do_check(lat);
        tests_run++;
        if ({timeout, pass} !== 2'b01) begin
            tests_failed++;
            $display("FAIL to_recover: got %b expected 01", {timeout, pass});
        end
`else
        for (int i = 1; i <= 120; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (avm_read) rdcyc++;
            if (done) ndone++;
        end
        tests_run++;
        if ({rdcyc, ndone, 31'd0, timeout} !== {32'd120, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL nto_wait: got rd=%0d done=%0d to=%b expected 120/0/0",
                rdcyc, ndone, timeout);
        end
        force_stall = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        @(posedge clock); #1;
        tests_run++;
        if ({lat, 29'd0, timeout, pass, busy} !== {32'd2, 32'd2}) begin
            tests_failed++;
            $display("FAIL nto_finish: got lat=%0d to=%b pass=%b busy=%b expected 2/0/1/0",
                lat, timeout, pass, busy);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int lat;
        mem[0] = 32'hdead_beef; mem[1] = EXP_TS;
        stall_id = 0; stall_ts = 5;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        tests_run++;
        if ({avm_read, avm_address} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rst_setup: got %b expected 11",
                {avm_read, avm_address});
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({avm_read, avm_address, busy, done, pass, id_match, ts_match,
             timeout} !== 8'b0) begin
            tests_failed++;
            $display("FAIL rst_async_ctl: got %b expected 00000000",
                {avm_read, avm_address, busy, done, pass, id_match,
                 ts_match, timeout});
        end
        tests_run++;
        if ({id_value, ts_value} !== 64'b0) begin
            tests_failed++;
            $display("FAIL rst_async_values: got %h expected 0",
                {id_value, ts_value});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        mem[0] = EXP_ID;
        stall_ts = 0;
        @(posedge clock); #1;
        do_check(lat);
        tests_run++;
        if ({lat, 31'd0, pass} !== {32'd3, 32'd1}) begin
            tests_failed++;
            $display("FAIL rst_clean_run: got lat=%0d pass=%b expected 3/1",
                lat, pass);
        end
    endtask

    initial begin
        mem[0] = EXP_ID;
        mem[1] = EXP_TS;
        test_reset();
        test_nominal();
        test_stalls();
        test_mismatch();
        test_random();
        test_start_busy();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that interrogates the System ID peripheral.
- Reads word 0 (system ID) and then word 1 (build timestamp), and compares both against expected values.
- Reports pass/fail to the boot/health logic.
- Sits on the same fabric as the SysID slave and lets hardware confirm the loaded bitstream before software trusts it.

Parameters:
- EXPECTED_ID, 32'h0000_0000, system ID value the fabric must return at word 0
- EXPECTED_TS, 32'd1616605598, build timestamp the fabric must return at word 1
- ADDR_W, 1, width of avm_address (word address)
- TIMEOUT_CYC, 1024, max consecutive waitrequest cycles per read (only with SYSID_CHECK_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a check when idle
- avm_address  out  ADDR_W  word address to the SysID slave
- avm_read  out  1  read request
- avm_readdata  in  32  read data, valid in the cycle read=1 and waitrequest=0
- avm_waitrequest  in  1  slave stall
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of check
- pass  out  1  sticky result of last check (id_match & ts_match & !timeout)
- id_match  out  1  sticky: word 0 equalled EXPECTED_ID
- ts_match  out  1  sticky: word 1 equalled EXPECTED_TS
- timeout  out  1  sticky: last check aborted on timeout
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

Behaviour:
- Reset (async assert, sync deassert at the clock edge): all outputs 0, state IDLE. A read in flight is dropped immediately, so avm_read falls asynchronously.
- States: IDLE, RD_ID, RD_TS, FIN.
- IDLE:
  - avm_read=0, avm_address=0.
  - start=1 → RD_ID on the next edge, and at that edge clear pass/id_match/ts_match/timeout.
  - id_value and ts_value hold their old values until overwritten.
- RD_ID:
  - avm_read=1, avm_address=0, both held stable while waitrequest=1.
  - On the edge with waitrequest=0: id_value<=readdata, id_match<=(readdata==EXPECTED_ID), → RD_TS.
- RD_TS:
  - Same as RD_ID but avm_address=1; captures into ts_value/ts_match.
  - → FIN.
- FIN:
  - avm_read=0, done=1 for exactly one cycle, pass<=id_match&ts_match, → IDLE.
- Latency: with waitrequest tied 0, start at edge N gives reads in cycles N+1 and N+2 and done in cycle N+3. Each stall cycle adds one.
- avm_read is never high in two states without an intervening accepted transfer; there are no back-to-back duplicate reads.
- start while busy (any non-IDLE state): ignored, not queued.
- start in the same cycle as the done pulse: ignored (state is FIN).
- busy = (state != IDLE).
- Address is zero-extended to ADDR_W. Comparisons are full 32-bit equality.

Optional Feature:
- Macro: SYSID_CHECK_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_ID/RD_TS while waitrequest=1, and clears on every accepted transfer and on state entry.
  - When the counter reaches TIMEOUT_CYC-1 with waitrequest still 1, on the next edge: avm_read<=0, timeout<=1, the match flag of the pending word stays 0, → FIN.
  - pass is 0 on a timeout.
- Undefined:
  - No counter; the reads wait indefinitely.
  - timeout is tied 0 and TIMEOUT_CYC is unused.

Decomposition:
- Package sysid_check_pkg:
  - state enum (IDLE, RD_ID, RD_TS, FIN)
  - word-offset constants SYSID_WORD_ID=0 and SYSID_WORD_TS=1
  - default expected-value constants
- One sub-module, sysid_check_timer: a clearable saturating stall counter with an expiry output. It is instantiated only under SYSID_CHECK_TIMEOUT_EN.

Test Plan:
- Nominal: waitrequest=0, slave returns 0 / 1616605598 → reads in cycles N+1 (addr 0) and N+2 (addr 1), done at N+3, pass=1, id_match=1, ts_match=1.
- Stalls: waitrequest=1 for 3 cycles on each read → address/read held stable throughout, done at N+9, pass=1, exactly two accepted transfers.
- Mismatch: word 1 returns 32'h1234_5678 → ts_value=32'h1234_5678, ts_match=0, id_match=1, pass=0. A following good run sets pass=1.
- Start during busy: a second start pulse in RD_TS → ignored, single done, no third read. Also apply start coincident with done → no new check.
- Timeout (macro on, TIMEOUT_CYC=8): waitrequest held 1 in RD_ID → read drops after 8 stall cycles, timeout=1, pass=0, done pulses once. Macro off: read stays high for 100+ cycles and timeout stays 0.
- Reset mid-read: assert reset during RD_TS stall → avm_read=0 with no clock edge, all outputs 0. After release, start runs a clean check with pass=1.
